// File: rtl/flag_pkg.sv
// flag_pkg: flag bit positions, condition codes and resolver FSM states shared by the flag/branch logic.
package flag_pkg;
  localparam int FZ = 3;
  localparam int FC = 2;
  localparam int FN = 1;
  localparam int FV = 0;
  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5;
  localparam logic [3:0] CC_VS = 4'h6;
  localparam logic [3:0] CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8;
  localparam logic [3:0] CC_LS = 4'h9;
  localparam logic [3:0] CC_GE = 4'hA;
  localparam logic [3:0] CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC;
  localparam logic [3:0] CC_LE = 4'hD;
  localparam logic [3:0] CC_AL = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;
  typedef enum logic {S_IDLE, S_WAIT} state_t;
endpackage

// File: rtl/flag_cond_eval.sv
// flag_cond_eval: combinational condition-code test of a {Z,C,N,V} flag vector.
module flag_cond_eval
  import flag_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       take_o
);
  logic z, c, n, v;
  assign z = flags_i[FZ];
  assign c = flags_i[FC];
  assign n = flags_i[FN];
  assign v = flags_i[FV];
  always_comb begin
    take_o = 1'b0;
    case (cond_i)
      CC_EQ: take_o = z;
      CC_NE: take_o = ~z;
      CC_CS: take_o = c;
      CC_CC: take_o = ~c;
      CC_MI: take_o = n;
      CC_PL: take_o = ~n;
      CC_VS: take_o = v;
      CC_VC: take_o = ~v;
      CC_HI: take_o = c & ~z;
      CC_LS: take_o = ~c | z;
      CC_GE: take_o = n == v;
      CC_LT: take_o = n != v;
      CC_GT: take_o = ~z & (n == v);
      CC_LE: take_o = z | (n != v);
      CC_AL: take_o = 1'b1;
      CC_NV: take_o = 1'b0;
      default: take_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/flag_branch_resolver.sv
// flag_branch_resolver: flag register, in-flight flag-op tracking and conditional branch resolution.
// Define FLAG_FWD_EN to resolve in the cycle the last pending flag write retires.
module flag_branch_resolver
  import flag_pkg::*;
#(
  parameter int PEND_W = 2,
  parameter int OFF_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iIssueFlagOp,
  output logic             oIssueStall,
  input  logic             iFlagWe,
  input  logic             iSigned,
  input  logic [31:0]      iResult,
  input  logic             iCarry,
  input  logic             iNegative,
  input  logic             iOverflow,
  input  logic             iBrValid,
  output logic             oBrReady,
  input  logic [3:0]       iBrCond,
  input  logic [31:0]      iBrPc,
  input  logic [OFF_W-1:0] iBrOff,
  input  logic             iFlush,
  output logic             oBrDone,
  output logic             oTaken,
  output logic [31:0]      oTarget,
  output logic             oRedirect,
  output logic [3:0]       oFlags
);
  localparam logic [PEND_W-1:0] MAX = '1;
  state_t state_q, state_d;
  logic [PEND_W-1:0] cnt_q, cnt_d;
  logic [3:0] flags_q, flags_d, flags_upd, cond_q, cond_d;
  logic [31:0] pc_q, pc_d, target_q, target_d, off_x, target;
  logic [OFF_W-1:0] off_q, off_d;
  logic done_q, done_d, taken_q, taken_d, redirect_q, redirect_d;
  logic issue, retire, accept, resolve, take, take_reg, fwd_hit;
  assign issue  = iIssueFlagOp & ~oIssueStall;
  assign retire = iFlagWe & (cnt_q != '0);
  assign flags_upd = {iResult == 32'd0,
                      iSigned ? flags_q[FC] : iCarry,
                      iSigned ? iNegative   : flags_q[FN],
                      iSigned ? iOverflow   : flags_q[FV]};
  flag_cond_eval u_reg (.cond_i(cond_q), .flags_i(flags_q), .take_o(take_reg));
`ifdef FLAG_FWD_EN
  logic take_fwd;
  assign fwd_hit = (state_q == S_WAIT) & (cnt_q == PEND_W'(1)) & iFlagWe & ~iIssueFlagOp;
  flag_cond_eval u_fwd (.cond_i(cond_q), .flags_i(flags_upd), .take_o(take_fwd));
  assign take = fwd_hit ? take_fwd : take_reg;
`else
  assign fwd_hit = 1'b0;
  assign take = take_reg;
`endif
  assign off_x  = {{(32-OFF_W){off_q[OFF_W-1]}}, off_q};
  assign target = pc_q + 32'd4 + (off_x << 2);
  assign accept  = ~iFlush & (state_q == S_IDLE) & iBrValid;
  assign resolve = ~iFlush & (state_q == S_WAIT) & ((cnt_q == '0) | fwd_hit);
  always_comb begin
    state_d    = iFlush ? S_IDLE : accept ? S_WAIT : resolve ? S_IDLE : state_q;
    cnt_d      = iFlush ? '0 : cnt_q + PEND_W'(issue) - PEND_W'(retire);
    flags_d    = iFlagWe ? flags_upd : flags_q;
    cond_d     = accept ? iBrCond : cond_q;
    pc_d       = accept ? iBrPc : pc_q;
    off_d      = accept ? iBrOff : off_q;
    done_d     = resolve;
    taken_d    = resolve & take;
    redirect_d = resolve & take;
    target_d   = resolve ? target : target_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      flags_q    <= '0;
      cond_q     <= '0;
      pc_q       <= '0;
      off_q      <= '0;
      done_q     <= 1'b0;
      taken_q    <= 1'b0;
      redirect_q <= 1'b0;
      target_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      flags_q    <= flags_d;
      cond_q     <= cond_d;
      pc_q       <= pc_d;
      off_q      <= off_d;
      done_q     <= done_d;
      taken_q    <= taken_d;
      redirect_q <= redirect_d;
      target_q   <= target_d;
    end
  end
  assign oIssueStall = cnt_q == MAX;
  assign oBrReady    = state_q == S_IDLE;
  assign oBrDone     = done_q;
  assign oTaken      = taken_q;
  assign oTarget     = target_q;
  assign oRedirect   = redirect_q;
  assign oFlags      = flags_q;
endmodule

// File: tb/tb_flag_branch_resolver.sv
// tb_flag_branch_resolver: directed and random checks against a behavioural model of the resolver.
module tb_flag_branch_resolver;
  localparam int MAXP = 3;
  logic clk = 0, rst = 1;
  logic iIssueFlagOp = 0, iFlagWe = 0, iSigned = 0, iCarry = 0, iNegative = 0, iOverflow = 0;
  logic [31:0] iResult = 32'h1, iBrPc = 0;
  logic iBrValid = 0, iFlush = 0;
  logic [3:0] iBrCond = 0;
  logic [15:0] iBrOff = 0;
  logic oIssueStall, oBrReady, oBrDone, oTaken, oRedirect;
  logic [31:0] oTarget;
  logic [3:0] oFlags;
  int checks = 0, errors = 0;

  flag_branch_resolver #(.PEND_W(2), .OFF_W(16)) dut (
    .clk(clk), .rst(rst), .iIssueFlagOp(iIssueFlagOp), .oIssueStall(oIssueStall),
    .iFlagWe(iFlagWe), .iSigned(iSigned), .iResult(iResult), .iCarry(iCarry),
    .iNegative(iNegative), .iOverflow(iOverflow), .iBrValid(iBrValid), .oBrReady(oBrReady),
    .iBrCond(iBrCond), .iBrPc(iBrPc), .iBrOff(iBrOff), .iFlush(iFlush), .oBrDone(oBrDone),
    .oTaken(oTaken), .oTarget(oTarget), .oRedirect(oRedirect), .oFlags(oFlags));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit cond_true(input int cc, input bit z, input bit c, input bit n, input bit v);
    case (cc)
      0: return z;           1: return !z;
      2: return c;           3: return !c;
      4: return n;           5: return !n;
      6: return v;           7: return !v;
      8: return c && !z;     9: return !c || z;
      10: return n == v;     11: return n != v;
      12: return !z && n == v;
      13: return z || n != v;
      14: return 1;
      default: return 0;
    endcase
  endfunction

  // Model state: pending count, flag bits and the branch held while waiting.
  bit m_valid = 0, m_wait = 0, mz, mc, mn, mv;
  int m_cnt;
  int b_cond;
  logic [31:0] b_pc, b_off;
  bit e_done, e_taken;
  logic [31:0] e_target;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1; m_wait = 0; m_cnt = 0;
      {mz, mc, mn, mv} = 4'b0;
      e_done = 0; e_taken = 0; e_target = 0;
    end else if (m_valid) begin
      bit nz, nc, nn, nv, res, use_new;
      nz = (iResult == 0);
      nc = iSigned ? mc : iCarry;
      nn = iSigned ? iNegative : mn;
      nv = iSigned ? iOverflow : mv;
      res = 0; use_new = 0;
      if (iFlush) m_wait = 0;
      else if (m_wait) begin
        if (m_cnt == 0) res = 1;
`ifdef FLAG_FWD_EN
        else if (m_cnt == 1 && iFlagWe && !iIssueFlagOp) begin res = 1; use_new = 1; end
`endif
      end else if (iBrValid) begin
        m_wait = 1; b_cond = int'(iBrCond); b_pc = iBrPc; b_off = 32'($signed(iBrOff));
      end
      e_done = res;
      e_taken = res && (use_new ? cond_true(b_cond, nz, nc, nn, nv) : cond_true(b_cond, mz, mc, mn, mv));
      if (res) begin
        m_wait = 0;
        e_target = b_pc + 4 + b_off * 4;
      end
      if (iFlush) m_cnt = 0;
      else m_cnt = m_cnt + ((iIssueFlagOp && m_cnt < MAXP) ? 1 : 0) - ((iFlagWe && m_cnt > 0) ? 1 : 0);
      if (iFlagWe) {mz, mc, mn, mv} = {nz, nc, nn, nv};
    end
  end

  always @(negedge clk) begin
    if (m_valid && !rst) begin
      chk("done", oBrDone, e_done);
      chk("redirect", oRedirect, e_done && e_taken);
      chk("flags", oFlags, {mz, mc, mn, mv});
      chk("stall", oIssueStall, m_cnt == MAXP);
      chk("ready", oBrReady, !m_wait);
      if (e_done) begin
        chk("taken", oTaken, e_taken);
        chk("target", oTarget, e_target);
      end
    end
  end

  task automatic cyc();
    @(posedge clk); @(negedge clk); #1;
  endtask

  task automatic clr();
    iIssueFlagOp = 0; iFlagWe = 0; iSigned = 0; iResult = 32'h1; iCarry = 0;
    iNegative = 0; iOverflow = 0; iBrValid = 0; iFlush = 0;
  endtask

  task automatic retire(input bit sgn, input logic [31:0] r, input bit c, input bit n, input bit v);
    iFlagWe = 1; iSigned = sgn; iResult = r; iCarry = c; iNegative = n; iOverflow = v;
  endtask

  // Branch with no pending ops: must resolve at the 2nd edge after acceptance.
  task automatic run_branch(input string nm, input logic [3:0] cc, input logic [31:0] pc,
                            input logic [15:0] off, input bit exp_t, input logic [31:0] exp_tg);
    int n = 0;
    iBrValid = 1; iBrCond = cc; iBrPc = pc; iBrOff = off;
    cyc();
    iBrValid = 0;
    do begin cyc(); n++; end while (!oBrDone && n < 10);
    chk({nm, "_lat"}, n, 1);
    chk({nm, "_taken"}, oTaken, exp_t);
    chk({nm, "_redir"}, oRedirect, exp_t);
    if (exp_t) chk({nm, "_tgt"}, oTarget, exp_tg);
  endtask

  initial begin
    // T1
    cyc(); cyc();
    chk("rst_flags", oFlags, 0); chk("rst_done", oBrDone, 0); chk("rst_taken", oTaken, 0);
    chk("rst_redir", oRedirect, 0); chk("rst_tgt", oTarget, 0);
    chk("rst_ready", oBrReady, 1); chk("rst_stall", oIssueStall, 0);
    rst = 0;
    retire(0, 0, 0, 0, 0); cyc(); clr();
    chk("t1_flags", oFlags, 4'b1000);
    run_branch("t1", 4'h0, 32'h100, 16'd3, 1, 32'h110);
    // T2
    iIssueFlagOp = 1; cyc(); cyc(); clr();
    iBrValid = 1; iBrCond = 4'hB; iBrPc = 32'h2000; iBrOff = 16'hFFFF; cyc(); clr();
    chk("t2_ready", oBrReady, 0);
    retire(0, 32'h5, 0, 0, 0); cyc();
    retire(1, 32'h80000000, 0, 1, 0); cyc(); clr();
`ifndef FLAG_FWD_EN
    chk("t2_nodone", oBrDone, 0);
    cyc();
`endif
    chk("t2_done", oBrDone, 1); chk("t2_taken", oTaken, 1); chk("t2_tgt", oTarget, 32'h2000);
    chk("t2_flags", oFlags, 4'b0010);
    // T3
    retire(0, 32'h7, 1, 0, 0); cyc(); clr();
    chk("t3_flags", oFlags, 4'b0110);
    run_branch("t3_cs", 4'h2, 32'h40, 16'd0, 1, 32'h44);
    run_branch("t3_pl", 4'h5, 32'h40, 16'd0, 0, 0);
    // T4
    iIssueFlagOp = 1; cyc(); cyc();
    chk("t4_nstall", oIssueStall, 0);
    cyc();
    chk("t4_stall", oIssueStall, 1);
    cyc(); clr();
    chk("t4_drop", oIssueStall, 1);
    retire(0, 32'h1, 0, 0, 0); cyc();
    chk("t4_unstall", oIssueStall, 0);
    cyc(); cyc(); cyc(); clr();
    run_branch("t4", 4'hE, 32'h0, 16'd2, 1, 32'hC);
    // T5
    iIssueFlagOp = 1; cyc(); clr();
    iBrValid = 1; iBrCond = 4'hE; iBrPc = 32'h300; iBrOff = 0; cyc(); clr(); cyc();
    iFlush = 1; cyc(); clr();
    chk("t5_done", oBrDone, 0); chk("t5_ready", oBrReady, 1);
    cyc();
    chk("t5_done2", oBrDone, 0);
    run_branch("t5", 4'hE, 32'h300, 16'd0, 1, 32'h304);
    // T6
    run_branch("t6_al", 4'hE, 32'hFFFFFFF8, 16'd1, 1, 32'h0);
    run_branch("t6_nv", 4'hF, 32'hFFFFFFF8, 16'd1, 0, 0);
    // Random phase
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      iFlush = ($urandom_range(0, 29) == 0);
      iIssueFlagOp = ($urandom_range(0, 2) == 0);
      iFlagWe = ($urandom_range(0, 2) == 0);
      iSigned = $urandom_range(0, 1);
      iResult = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      iCarry = $urandom_range(0, 1);
      iNegative = $urandom_range(0, 1);
      iOverflow = $urandom_range(0, 1);
      iBrValid = ($urandom_range(0, 3) == 0);
      iBrCond = 4'($urandom_range(0, 15));
      iBrPc = $urandom;
      iBrOff = 16'($urandom);
      cyc();
    end
    rst = 0; clr(); cyc(); cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
